// File: rtl/hex_display_pkg.sv
// Shared types and constants for the hex display arbiter.
package hex_display_pkg;

   localparam int DIGIT_W              = 4;
   localparam int NUM_DIGITS           = 6;
   localparam int VALUE_W              = DIGIT_W * NUM_DIGITS;
   localparam int DEFAULT_DWELL_CYCLES = 50_000_000;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_t;

endpackage

// File: rtl/hex_display_arbiter_rr_next_valid.sv
// Rotating-priority search: first set bit of req_valid at start, start+1, ...
// wrapping modulo NUM_REQ.
module rr_next_valid
   import hex_display_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int OWNER_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [OWNER_W-1:0] start,
   output logic               found,
   output logic [OWNER_W-1:0] index
);

   logic [OWNER_W:0] cand;

   // Walk from the farthest offset down so the nearest valid candidate wins.
   always_comb begin
      found = 1'b0;
      index = '0;
      cand  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, start} + (OWNER_W+1)'(k);
         if (cand >= (OWNER_W+1)'(NUM_REQ)) begin
            cand = cand - (OWNER_W+1)'(NUM_REQ);
         end
         if (req_valid[cand[OWNER_W-1:0]]) begin
            found = 1'b1;
            index = cand[OWNER_W-1:0];
         end
      end
   end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin time-slicing of the 6-digit hex display among NUM_REQ requesters,
// each grant held for DWELL_CYCLES unless the owner drops out first.
module hex_display_arbiter
   import hex_display_pkg::*;
#(
   parameter  int NUM_REQ      = 4,
   parameter  int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
   localparam int OWNER_W      = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [VALUE_W*NUM_REQ-1:0] req_value,
   output logic [VALUE_W-1:0]         disp_value,
   output logic                       disp_blank,
   output logic [OWNER_W-1:0]         disp_owner,
   output logic [NUM_REQ-1:0]         grant_pulse
);

   localparam int                 CNT_W      = $clog2(DWELL_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [OWNER_W-1:0] OWNER_LAST = OWNER_W'(NUM_REQ - 1);

   state_t               state_q, state_d;
   logic [OWNER_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [VALUE_W-1:0]   disp_value_q, disp_value_d;
   logic                 disp_blank_q, disp_blank_d;
   logic [OWNER_W-1:0]   disp_owner_q, disp_owner_d;
   logic [NUM_REQ-1:0]   grant_pulse_q, grant_pulse_d;

   logic [VALUE_W-1:0]   req_value_arr [NUM_REQ];
   logic [NUM_REQ-1:0]   search_mask;
   logic [OWNER_W-1:0]   search_start;
   logic                 search_found;
   logic [OWNER_W-1:0]   search_idx;
   logic                 do_grant;
   logic                 do_idle;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_value_arr[gi] = req_value[VALUE_W*gi +: VALUE_W];
      end
   endgenerate

   // While showing, ptr_q is the owner, so one search from ptr+1 with the
   // owner masked out serves IDLE grants, expiry rotation and owner drops.
   always_comb begin
      search_mask  = req_valid;
      search_start = (ptr_q == OWNER_LAST) ? '0 : ptr_q + OWNER_W'(1);
      if (state_q == SHOW) begin
         search_mask[ptr_q] = 1'b0;
      end
   end

   rr_next_valid #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_next_valid (
      .req_valid (search_mask),
      .start     (search_start),
      .found     (search_found),
      .index     (search_idx)
   );

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      disp_value_d  = disp_value_q;
      disp_blank_d  = disp_blank_q;
      disp_owner_d  = disp_owner_q;
      grant_pulse_d = '0;
      do_grant      = 1'b0;
      do_idle       = 1'b0;

      case (state_q)
         IDLE: begin
            do_grant = search_found;
         end
         SHOW: begin
            if (!req_valid[ptr_q] || cnt_q == CNT_LAST) begin
               if (search_found) begin
                  do_grant = 1'b1;
               end else if (req_valid[ptr_q]) begin
                  cnt_d        = '0;
                  disp_value_d = req_value_arr[ptr_q];
               end else begin
                  do_idle = 1'b1;
               end
            end else begin
               cnt_d        = cnt_q + CNT_W'(1);
               disp_value_d = req_value_arr[ptr_q];
            end
         end
         default: do_idle = 1'b1;
      endcase

      if (do_grant) begin
         state_d                   = SHOW;
         ptr_d                     = search_idx;
         disp_owner_d              = search_idx;
         cnt_d                     = '0;
         disp_blank_d              = 1'b0;
         disp_value_d              = req_value_arr[search_idx];
         grant_pulse_d[search_idx] = 1'b1;
      end

      // ptr_q is left alone so the next search resumes after the last owner.
      if (do_idle) begin
         state_d      = IDLE;
         cnt_d        = '0;
         disp_blank_d = 1'b1;
         disp_value_d = '0;
         disp_owner_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         ptr_q         <= OWNER_LAST;
         cnt_q         <= '0;
         disp_value_q  <= '0;
         disp_blank_q  <= 1'b1;
         disp_owner_q  <= '0;
         grant_pulse_q <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         disp_value_q  <= disp_value_d;
         disp_blank_q  <= disp_blank_d;
         disp_owner_q  <= disp_owner_d;
         grant_pulse_q <= grant_pulse_d;
      end
   end

   assign disp_value  = disp_value_q;
   assign disp_blank  = disp_blank_q;
   assign disp_owner  = disp_owner_q;
   assign grant_pulse = grant_pulse_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with NUM_REQ=4, DWELL_CYCLES=4.
module tb_hex_display_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DWELL   = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [95:0] req_value;
   logic [23:0] disp_value;
   logic        disp_blank;
   logic [1:0]  disp_owner;
   logic [3:0]  grant_pulse;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hex_display_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .DWELL_CYCLES (DWELL)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_value   (req_value),
      .disp_value  (disp_value),
      .disp_blank  (disp_blank),
      .disp_owner  (disp_owner),
      .grant_pulse (grant_pulse)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic blank, input logic [1:0] own,
                             input logic [3:0] pulse, input logic [23:0] val);
      chk({tag, ".blank"}, 32'(disp_blank),  32'(blank));
      chk({tag, ".owner"}, 32'(disp_owner),  32'(own));
      chk({tag, ".pulse"}, 32'(grant_pulse), 32'(pulse));
      chk({tag, ".value"}, 32'(disp_value),  32'(val));
      $display("%-10s blank=%0d owner=%0d pulse=%b value=%06h", tag,
               disp_blank, disp_owner, grant_pulse, disp_value);
   endtask

   int          seq_own [4] = '{0, 1, 3, 0};
   logic [23:0] seq_val [4] = '{24'h00000A, 24'h00000B, 24'h00000D, 24'h00000A};

   initial begin
      reset     = 1'b1;
      req_valid = 4'b0000;
      req_value = '0;

      // 1: reset held, nothing requested
      for (int c = 0; c < 3; c++) begin
         step();
         expect_out($sformatf("t1.r%0d", c), 1'b1, 2'd0, 4'b0000, 24'h0);
      end
      reset = 1'b0;
      step();
      expect_out("t1.rel", 1'b1, 2'd0, 4'b0000, 24'h0);

      // 2: single requester keeps the display across expiries without pulses
      req_value[2*24 +: 24] = 24'h123456;
      req_valid             = 4'b0100;
      step();
      expect_out("t2.grant", 1'b0, 2'd2, 4'b0100, 24'h123456);
      for (int c = 0; c < 9; c++) begin
         step();
         expect_out($sformatf("t2.h%0d", c), 1'b0, 2'd2, 4'b0000, 24'h123456);
      end

      // 3: round robin over 0,1,3 after a reset puts the pointer back at 3
      reset     = 1'b1;
      req_valid = 4'b0000;
      step();
      expect_out("t3.rst", 1'b1, 2'd0, 4'b0000, 24'h0);
      reset                 = 1'b0;
      req_value[0*24 +: 24] = 24'h00000A;
      req_value[1*24 +: 24] = 24'h00000B;
      req_value[3*24 +: 24] = 24'h00000D;
      req_valid             = 4'b1011;
      for (int c = 0; c < 16; c++) begin
         step();
         expect_out($sformatf("t3.c%0d", c), 1'b0, 2'(seq_own[c/4]),
                    (c % 4 == 0) ? (4'b0001 << seq_own[c/4]) : 4'b0000, seq_val[c/4]);
      end

      // 4: owner 1 drops at counter 1, hand-off to 3, then everyone drops
      step();
      expect_out("t4.g1", 1'b0, 2'd1, 4'b0010, 24'h00000B);
      step();
      expect_out("t4.c1", 1'b0, 2'd1, 4'b0000, 24'h00000B);
      req_valid = 4'b1001;
      step();
      expect_out("t4.drop", 1'b0, 2'd3, 4'b1000, 24'h00000D);
      step();
      expect_out("t4.c1b", 1'b0, 2'd3, 4'b0000, 24'h00000D);
      req_valid = 4'b0000;
      step();
      expect_out("t4.idle", 1'b1, 2'd0, 4'b0000, 24'h0);

      // 5: late requester waits for expiry; owner value change tracked live
      req_value[0*24 +: 24] = 24'h000001;
      req_value[2*24 +: 24] = 24'h222222;
      req_valid             = 4'b0001;
      step();
      expect_out("t5.grant", 1'b0, 2'd0, 4'b0001, 24'h000001);
      req_valid             = 4'b0101;
      req_value[0*24 +: 24] = 24'h000002;
      step();
      expect_out("t5.c1", 1'b0, 2'd0, 4'b0000, 24'h000002);
      step();
      expect_out("t5.c2", 1'b0, 2'd0, 4'b0000, 24'h000002);
      step();
      expect_out("t5.c3", 1'b0, 2'd0, 4'b0000, 24'h000002);
      step();
      expect_out("t5.exp", 1'b0, 2'd2, 4'b0100, 24'h222222);

      // 6: reset mid-slot, then regrant from a fresh pointer
      step();
      expect_out("t6.c1", 1'b0, 2'd2, 4'b0000, 24'h222222);
      step();
      expect_out("t6.c2", 1'b0, 2'd2, 4'b0000, 24'h222222);
      reset = 1'b1;
      step();
      expect_out("t6.rst", 1'b1, 2'd0, 4'b0000, 24'h0);
      reset                 = 1'b0;
      req_value[1*24 +: 24] = 24'h0B0B0B;
      req_valid             = 4'b0010;
      step();
      expect_out("t6.grant", 1'b0, 2'd1, 4'b0010, 24'h0B0B0B);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
